// File: rtl/axi4lite_req_arbiter_if.sv
// Bundle for the two requester channels, the shared AXI4-Lite master user port and busy.
// "slave" is the arbiter's view; "master" is the view of the clients plus the master core.
interface axi4lite_req_arbiter_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic                  req0_valid;
  logic                  req0_write;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_ready;
  logic                  req0_done;
  logic [DATA_WIDTH-1:0] req0_rdata;
  logic                  req0_err;

  logic                  req1_valid;
  logic                  req1_write;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_ready;
  logic                  req1_done;
  logic [DATA_WIDTH-1:0] req1_rdata;
  logic                  req1_err;

  logic                  m_start_write;
  logic                  m_start_read;
  logic [ADDR_WIDTH-1:0] m_write_addr;
  logic [ADDR_WIDTH-1:0] m_read_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  m_done;
  logic [DATA_WIDTH-1:0] m_read_data;

  logic                  busy;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, req0_done, req0_rdata, req0_err,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, req1_done, req1_rdata, req1_err,
    output m_start_write, m_start_read, m_write_addr, m_read_addr, m_wdata,
    input  m_done, m_read_data,
    output busy
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, req0_done, req0_rdata, req0_err,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, req1_done, req1_rdata, req1_err,
    input  m_start_write, m_start_read, m_write_addr, m_read_addr, m_wdata,
    output m_done, m_read_data,
    input  busy
  );
endinterface

// File: rtl/axi4lite_req_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI4-Lite master user port.
// Optional WAIT timeout abort is enabled by defining ARB_TIMEOUT_EN.
module axi4lite_req_arbiter #(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  axi4lite_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q;
  logic                  gnt_q;
  logic                  last_grant_q;
  logic                  cmd_write_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [DATA_WIDTH-1:0] cmd_wdata_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic                  m_done_q;
  logic                  ready0_q;
  logic                  ready1_q;
  logic                  done0_q;
  logic                  done1_q;
  logic                  start_write_q;
  logic                  start_read_q;

  logic                  done_evt;
  logic                  pick1;
  logic                  pick_write;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [DATA_WIDTH-1:0] pick_wdata;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err0_q;
  logic             err1_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  // Rising-edge detect keeps a level left high by the previous transaction from completing this one.
  assign done_evt = bus.m_done & ~m_done_q;

  // On a tie the requester that was not served last wins.
  assign pick1      = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
  assign pick_write = pick1 ? bus.req1_write : bus.req0_write;
  assign pick_addr  = pick1 ? bus.req1_addr  : bus.req0_addr;
  assign pick_wdata = pick1 ? bus.req1_wdata : bus.req0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= 1'b0;
      last_grant_q  <= 1'b1;
      cmd_write_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      m_done_q      <= 1'b0;
      ready0_q      <= 1'b0;
      ready1_q      <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      start_write_q <= 1'b0;
      start_read_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q         <= '0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
`endif
    end else begin
      m_done_q <= bus.m_done;
      case (state_q)
        IDLE: begin
          if (bus.req0_valid || bus.req1_valid) begin
            gnt_q         <= pick1;
            cmd_write_q   <= pick_write;
            cmd_addr_q    <= pick_addr;
            cmd_wdata_q   <= pick_wdata;
            ready0_q      <= ~pick1;
            ready1_q      <= pick1;
            start_write_q <= pick_write;
            start_read_q  <= ~pick_write;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          ready0_q      <= 1'b0;
          ready1_q      <= 1'b0;
          start_write_q <= 1'b0;
          start_read_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          cnt_q         <= '0;
`endif
          state_q       <= WAIT;
        end
        WAIT: begin
          // A completion on the same cycle as the timeout takes priority.
          if (done_evt) begin
            if (!cmd_write_q) begin
              if (gnt_q) rdata1_q <= bus.m_read_data;
              else       rdata0_q <= bus.m_read_data;
            end
            done0_q <= ~gnt_q;
            done1_q <= gnt_q;
            state_q <= RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            if (gnt_q) rdata1_q <= '0;
            else       rdata0_q <= '0;
            done0_q <= ~gnt_q;
            done1_q <= gnt_q;
            err0_q  <= ~gnt_q;
            err1_q  <= gnt_q;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          done0_q      <= 1'b0;
          done1_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          err0_q       <= 1'b0;
          err1_q       <= 1'b0;
`endif
          last_grant_q <= gnt_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready    = ready0_q;
  assign bus.req1_ready    = ready1_q;
  assign bus.req0_done     = done0_q;
  assign bus.req1_done     = done1_q;
  assign bus.req0_rdata    = rdata0_q;
  assign bus.req1_rdata    = rdata1_q;
  assign bus.m_start_write = start_write_q;
  assign bus.m_start_read  = start_read_q;
  assign bus.m_write_addr  = cmd_addr_q;
  assign bus.m_read_addr   = cmd_addr_q;
  assign bus.m_wdata       = cmd_wdata_q;
  assign bus.busy          = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
  assign bus.req0_err = err0_q;
  assign bus.req1_err = err1_q;
`else
  assign bus.req0_err = 1'b0;
  assign bus.req1_err = 1'b0;
`endif

endmodule
